outbuf_wr_arbiter: RTL
======================

// Module: outbuf_wr_arbiter
// PURPOSE
//  Shares the single output-buffer write port between N_REQ PE-row psum producers.
//  Round-robin arbitration; holds losers and all requesters while outbuf_full is high.
//  Counts psums per requester against a programmed total. Pulses all_done once every
//  row has delivered its total. Sits between the PE rows and the output buffer.
// PARAMETERS
//  N_REQ      4   number of requesters, >=2
//  DATA_W     16  psum width
//  CNT_W      8   width of per-requester psum count
// PORTS
//  clk           in   1             clock
//  rst           in   1             synchronous, active-high reset
//  start         in   1             latch num_psums, begin a layer pass (IDLE only)
//  num_psums     in   CNT_W         psums each requester must write this pass
//  req           in   N_REQ         per-requester write request (level, held until granted)
//  req_data      in   N_REQ*DATA_W  psum data; slice i = [i*DATA_W +: DATA_W]
//  outbuf_full   in   1             output buffer cannot accept a write this cycle
//  grant         out  N_REQ         one-hot grant; write accepted this cycle
//  stall         out  N_REQ         requester i must hold its req/data
//  outbuf_write  out  1             write strobe to output buffer
//  outbuf_wdata  out  DATA_W        muxed data of the granted requester
//  outbuf_wsrc   out  $clog2(N_REQ) index of the granted requester
//  busy          out  1             pass in progress (state ARB)
//  all_done      out  1             one-cycle pulse at end of pass
// BEHAVIOUR
//  - Reset (sync): state=IDLE, rr_ptr=0, all counters=0, done_mask=0, total latched=0.
//    All outputs 0. Reset mid-pass aborts the pass; no all_done is produced.
//  - FSM states: IDLE -> ARB on start. ARB -> DONE when done_mask all ones. DONE -> IDLE
//    after one cycle. start is ignored outside IDLE.
//  - On start: total<=num_psums, counters<=0, done_mask<=0. If num_psums==0, go IDLE->DONE
//    directly. all_done pulses one cycle later.
//  - Eligible: elig[i] = req[i] & ~done_mask[i]. Grant is valid only in ARB with outbuf_full==0.
//  - Grant is combinational (zero latency). It picks the first eligible index scanning
//    rr_ptr, rr_ptr+1, ... modulo N_REQ.
//    On grant of k: rr_ptr<=(k+1) mod N_REQ, cnt[k]<=cnt[k]+1.
//    If cnt[k]+1==total, set done_mask[k]<=1.
//  - outbuf_write = |grant. outbuf_wdata/outbuf_wsrc come from the granted slice; both are 0
//    when no grant.
//  - stall[i] = elig[i] & ~grant[i] while busy. In IDLE/DONE stall=req & ~done_mask.
//    Completed requesters never stall; their req is ignored.
//  - outbuf_full high: no grant, outbuf_write=0, all eligible requesters stalled.
//    rr_ptr and counters hold.
//  - Fairness: a continuously requesting, not-yet-done row is granted within N_REQ
//    non-full cycles.
//  - all_done is high exactly in DONE. busy is high exactly in ARB.
//  - Counters are CNT_W wide and never exceed total, so there is no wrap.
// CONFIGURATION
//  OUTBUF_ARB_ERR_EN defined:
//    - Adds output err (1 bit). err is sticky; it is cleared by rst or by an accepted start.
//    - err sets when req[i] is high while done_mask[i]==1 during ARB.
//    - err also sets when start is asserted outside IDLE.
//  OUTBUF_ARB_ERR_EN undefined:
//    - The err port is absent. Both conditions are silently ignored; behaviour is otherwise
//      identical.
// TESTING
//  1 N_REQ=4, num_psums=2, all req held high, full=0 -> grants 0,1,2,3,0,1,2,3.
//    8 writes; all_done pulses 1 cycle after last grant.
//  2 Only req[2] high, rr_ptr=0 -> grant=4'b0100 same cycle. outbuf_wsrc=2, wdata=slice 2.
//    Next rr_ptr=3.
//  3 All req high, outbuf_full=1 for 5 cycles -> no writes, stall=4'b1111, counters frozen.
//    Rotation resumes from the same rr_ptr.
//  4 num_psums=0, start -> busy never set. all_done high 1 cycle after start, no writes.
//  5 rst asserted mid-pass after 3 writes -> next cycle all outputs 0, IDLE, no all_done.
//    A new start restarts the counts from 0.
//  6 (ERR_EN) row 1 done, keeps req[1]=1 -> row 1 gets no grant, stall[1]=0, err=1 until next start.

Source files
------------

// File: rtl/outbuf_wr_arbiter_if.sv
// Output-buffer write bus: PE-row requests in, muxed write out.
// master = arbiter side, slave = requester/buffer side.
interface outbuf_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  localparam int SRC_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        stall;
  logic                    outbuf_full;
  logic                    outbuf_write;
  logic [DATA_W-1:0]       outbuf_wdata;
  logic [SRC_W-1:0]        outbuf_wsrc;

  modport master (
    input  req, req_data, outbuf_full,
    output grant, stall, outbuf_write,
    output outbuf_wdata, outbuf_wsrc
  );

  modport slave (
    output req, req_data, outbuf_full,
    input  grant, stall, outbuf_write,
    input  outbuf_wdata, outbuf_wsrc
  );
endinterface

// File: rtl/outbuf_wr_arbiter.sv
// Round-robin arbiter sharing the output-buffer write port among PE rows.
// Optional OUTBUF_ARB_ERR_EN adds a sticky protocol error output.
module outbuf_wr_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_psums,
  outbuf_wr_arbiter_if.master bus,
  output logic             busy,
  output logic             all_done
`ifdef OUTBUF_ARB_ERR_EN
  ,
  output logic             err
`endif
);
  localparam int SRC_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic [SRC_W-1:0] rr_ptr;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] done_mask;
  logic [N_REQ-1:0] dm_next;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] gidx;
  logic [SRC_W-1:0] rr_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             found;
  logic             hit;
  logic             go;

  assign elig = bus.req & ~done_mask;
  assign go   = (state == IDLE) && start;

  // Rotating priority scan starting at rr_ptr
  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    gidx  = '0;
    if (state == ARB && !bus.outbuf_full) begin
      for (int j = 0; j < N_REQ; j++) begin
        p = int'(rr_ptr) + j;
        if (p >= N_REQ) p = p - N_REQ;
        if (!found && elig[p]) begin
          found = 1'b1;
          gidx  = SRC_W'(p);
        end
      end
    end
  end

  always_comb begin
    grant   = '0;
    rr_next = '0;
    if (found) grant = N_REQ'(1) << gidx;
    if (gidx != SRC_W'(N_REQ - 1))
      rr_next = gidx + 1'b1;
    cnt_inc = cnt[gidx] + 1'b1;
    hit     = found && (cnt_inc == total);
    dm_next = hit ? (done_mask | grant) : done_mask;
  end

  assign bus.grant        = grant;
  assign bus.stall        = elig & ~grant;
  assign bus.outbuf_write = found;
  assign bus.outbuf_wsrc  = gidx;
  assign bus.outbuf_wdata = found
    ? bus.req_data[gidx*DATA_W +: DATA_W]
    : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    busy     = 1'b0;
    all_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_d = (num_psums == '0) ? DONE : ARB;
      end
      ARB: begin
        busy = 1'b1;
        if (&dm_next) state_d = DONE;
      end
      DONE: begin
        all_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      total     <= '0;
      done_mask <= '0;
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
    end else if (go) begin
      total     <= num_psums;
      done_mask <= '0;
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= '0;
    end else if (found) begin
      rr_ptr    <= rr_next;
      cnt[gidx] <= cnt_inc;
      done_mask <= dm_next;
    end
  end

`ifdef OUTBUF_ARB_ERR_EN
  // Sticky: finished row still requesting, or start while busy
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (go)
      err <= 1'b0;
    else if ((state == ARB && |(bus.req & done_mask))
             || (start && state != IDLE))
      err <= 1'b1;
  end
`endif

endmodule
